demux_1to4_skid: RTL and testbench

- Per-source ingress stage of the NtoM crossbar.
- Accepts one valid/ready stream carrying a payload plus a 2-bit destination select.
- Buffers each beat in a 2-entry skid buffer, then steers it to exactly one of four destination ports.
- Each destination port feeds the vld/pld/rdy input of one N-to-1 arbitrating mux, so there is one instance per crossbar source.
- Registered outputs, full throughput, no combinational path from any rdy_dst to rdy_src.

---
 rtl/demux_1to4_skid.sv | 150 +++++++++++++++
 tb/tb_demux_1to4_skid.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_skid.sv
// Per-source crossbar ingress: 2-entry skid buffer steering each beat to one of four ports.
// Optional stall counter enabled by defining DEMUX_1TO4_STALL_CNT_EN.
module demux_1to4_skid #(
  parameter int PLD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_src,
  input  logic [PLD_W-1:0] pld_src,
  input  logic [1:0]       sel_src,
  output logic             rdy_src,
  output logic             vld_dst0,
  output logic             vld_dst1,
  output logic             vld_dst2,
  output logic             vld_dst3,
  output logic [PLD_W-1:0] pld_dst0,
  output logic [PLD_W-1:0] pld_dst1,
  output logic [PLD_W-1:0] pld_dst2,
  output logic [PLD_W-1:0] pld_dst3,
  input  logic             rdy_dst0,
  input  logic             rdy_dst1,
  input  logic             rdy_dst2,
  input  logic             rdy_dst3
`ifdef DEMUX_1TO4_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  logic             main_vld_q, main_vld_d;
  logic [PLD_W-1:0] main_pld_q, main_pld_d;
  logic [1:0]       main_sel_q, main_sel_d;
  logic             skid_vld_q, skid_vld_d;
  logic [PLD_W-1:0] skid_pld_q, skid_pld_d;
  logic [1:0]       skid_sel_q, skid_sel_d;

  logic [3:0]            dst_vld_q, dst_vld_d;
  logic [3:0][PLD_W-1:0] dst_pld_q, dst_pld_d;

  logic [3:0] rdy_dst_s;
  logic       in_fire_s;
  logic       out_fire_s;

  assign rdy_dst_s  = {rdy_dst3, rdy_dst2, rdy_dst1, rdy_dst0};
  assign in_fire_s  = vld_src & ~skid_vld_q;
  assign out_fire_s = main_vld_q & rdy_dst_s[main_sel_q];

  // Skid/main next state; skid has priority so FIFO order is preserved.
  always_comb begin
    main_vld_d = main_vld_q;
    main_pld_d = main_pld_q;
    main_sel_d = main_sel_q;
    skid_vld_d = skid_vld_q;
    skid_pld_d = skid_pld_q;
    skid_sel_d = skid_sel_q;
    if (skid_vld_q && (out_fire_s || !main_vld_q)) begin
      main_vld_d = 1'b1;
      main_pld_d = skid_pld_q;
      main_sel_d = skid_sel_q;
      skid_vld_d = 1'b0;
    end else if (in_fire_s && (!main_vld_q || out_fire_s)) begin
      main_vld_d = 1'b1;
      main_pld_d = pld_src;
      main_sel_d = sel_src;
    end else if (in_fire_s && main_vld_q && !out_fire_s) begin
      skid_vld_d = 1'b1;
      skid_pld_d = pld_src;
      skid_sel_d = sel_src;
    end else if (out_fire_s) begin
      main_vld_d = 1'b0;
    end else begin
      main_vld_d = main_vld_q;
    end
  end

  // Pre-decode the next main entry so per-port outputs come straight from flops.
  always_comb begin
    dst_vld_d = 4'b0000;
    dst_pld_d = {4{{PLD_W{1'b0}}}};
    for (int k = 0; k < 4; k++) begin
      if (main_vld_d && (main_sel_d == k[1:0])) begin
        dst_vld_d[k] = 1'b1;
        dst_pld_d[k] = main_pld_d;
      end else begin
        dst_vld_d[k] = 1'b0;
        dst_pld_d[k] = {PLD_W{1'b0}};
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      main_pld_q <= {PLD_W{1'b0}};
      main_sel_q <= 2'd0;
      skid_vld_q <= 1'b0;
      skid_pld_q <= {PLD_W{1'b0}};
      skid_sel_q <= 2'd0;
      dst_vld_q  <= 4'b0000;
      dst_pld_q  <= {4{{PLD_W{1'b0}}}};
      rdy_src    <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      main_pld_q <= main_pld_d;
      main_sel_q <= main_sel_d;
      skid_vld_q <= skid_vld_d;
      skid_pld_q <= skid_pld_d;
      skid_sel_q <= skid_sel_d;
      dst_vld_q  <= dst_vld_d;
      dst_pld_q  <= dst_pld_d;
      rdy_src    <= ~skid_vld_d;
    end
  end

  assign vld_dst0 = dst_vld_q[0];
  assign vld_dst1 = dst_vld_q[1];
  assign vld_dst2 = dst_vld_q[2];
  assign vld_dst3 = dst_vld_q[3];
  assign pld_dst0 = dst_pld_q[0];
  assign pld_dst1 = dst_pld_q[1];
  assign pld_dst2 = dst_pld_q[2];
  assign pld_dst3 = dst_pld_q[3];

`ifdef DEMUX_1TO4_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the head beat waits on its destination.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_vld_q && !out_fire_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1to4_skid.sv
// Directed self-checking bench for demux_1to4_skid (stall counter checks when
// DEMUX_1TO4_STALL_CNT_EN is defined).
module tb_demux_1to4_skid;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_src = 1'b0;
  logic [3:0] pld_src = 4'h0;
  logic [1:0] sel_src = 2'd0;
  logic       rdy_src;
  logic       vld_dst0, vld_dst1, vld_dst2, vld_dst3;
  logic [3:0] pld_dst0, pld_dst1, pld_dst2, pld_dst3;
  logic       rdy_dst0 = 1'b1, rdy_dst1 = 1'b1, rdy_dst2 = 1'b1, rdy_dst3 = 1'b1;
`ifdef DEMUX_1TO4_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  demux_1to4_skid #(.PLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .vld_src(vld_src), .pld_src(pld_src), .sel_src(sel_src), .rdy_src(rdy_src),
    .vld_dst0(vld_dst0), .vld_dst1(vld_dst1), .vld_dst2(vld_dst2), .vld_dst3(vld_dst3),
    .pld_dst0(pld_dst0), .pld_dst1(pld_dst1), .pld_dst2(pld_dst2), .pld_dst3(pld_dst3),
    .rdy_dst0(rdy_dst0), .rdy_dst1(rdy_dst1), .rdy_dst2(rdy_dst2), .rdy_dst3(rdy_dst3)
`ifdef DEMUX_1TO4_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [3:0]  vld_all = {vld_dst3, vld_dst2, vld_dst1, vld_dst0};
  wire [15:0] pld_all = {pld_dst3, pld_dst2, pld_dst1, pld_dst0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a beat offered upstream
    vld_src = 1'b1; pld_src = 4'hA; sel_src = 2'd0;
    repeat (3) tick();
    check_eq("rst_vld", {28'd0, vld_all}, 32'h0);
    check_eq("rst_pld", {16'd0, pld_all}, 32'h0);
    check_eq("rst_rdy", {31'd0, rdy_src}, 32'h1);
    vld_src = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_vld", {28'd0, vld_all}, 32'h0);
    tick();
    check_eq("post_rst_vld2", {28'd0, vld_all}, 32'h0);

    // Single beat to port 2
    vld_src = 1'b1; pld_src = 4'h5; sel_src = 2'd2;
    tick();
    vld_src = 1'b0;
    check_eq("single_vld", {28'd0, vld_all}, 32'h4);
    check_eq("single_pld", {16'd0, pld_all}, 32'h0500);
    tick();
    check_eq("single_gone", {28'd0, vld_all}, 32'h0);
    check_eq("single_pld0", {16'd0, pld_all}, 32'h0);

    // Streaming: 8 back-to-back beats cycling destinations
    for (int i = 0; i < 8; i++) begin
      check_eq("stream_rdy", {31'd0, rdy_src}, 32'h1);
      vld_src = 1'b1; pld_src = 4'(i + 1); sel_src = 2'(i % 4);
      tick();
      check_eq("stream_vld", {28'd0, vld_all}, 32'(1 << (i % 4)));
      check_eq("stream_pld", {16'd0, pld_all}, 32'((i + 1) << (4 * (i % 4))));
    end
    vld_src = 1'b0;
    tick();
    check_eq("stream_end", {28'd0, vld_all}, 32'h0);

    // Backpressure on port 1 fills the skid
    rdy_dst1 = 1'b0;
    vld_src = 1'b1; pld_src = 4'h3; sel_src = 2'd1;
    tick();
    check_eq("bp_first_pld", {16'd0, pld_all}, 32'h0030);
    check_eq("bp_first_rdy", {31'd0, rdy_src}, 32'h1);
    pld_src = 4'h7;
    tick();
    check_eq("bp_full_rdy", {31'd0, rdy_src}, 32'h0);
    check_eq("bp_full_pld", {16'd0, pld_all}, 32'h0030);
    pld_src = 4'hF; sel_src = 2'd2;
    repeat (2) tick();
    check_eq("bp_hold_rdy", {31'd0, rdy_src}, 32'h0);
    check_eq("bp_hold_vld", {28'd0, vld_all}, 32'h2);
    check_eq("bp_hold_pld", {16'd0, pld_all}, 32'h0030);
    vld_src = 1'b0; rdy_dst1 = 1'b1;
    tick();
    check_eq("bp_drain2_pld", {16'd0, pld_all}, 32'h0070);
    check_eq("bp_drain2_vld", {28'd0, vld_all}, 32'h2);
    check_eq("bp_drain_rdy", {31'd0, rdy_src}, 32'h1);
    tick();
    check_eq("bp_empty", {28'd0, vld_all}, 32'h0);

    // Head-of-line blocking: sel=0 stalls a later sel=3 beat
    rdy_dst0 = 1'b0;
    vld_src = 1'b1; pld_src = 4'h9; sel_src = 2'd0;
    tick();
    pld_src = 4'hC; sel_src = 2'd3;
    tick();
    vld_src = 1'b0;
    check_eq("hol_vld", {28'd0, vld_all}, 32'h1);
    check_eq("hol_pld", {16'd0, pld_all}, 32'h0009);
    tick();
    check_eq("hol_hold", {28'd0, vld_all}, 32'h1);
    check_eq("hol_rdy", {31'd0, rdy_src}, 32'h0);
    rdy_dst0 = 1'b1;
    tick();
    check_eq("hol_rel_vld", {28'd0, vld_all}, 32'h8);
    check_eq("hol_rel_pld", {16'd0, pld_all}, 32'hC000);
    tick();
    check_eq("hol_empty", {28'd0, vld_all}, 32'h0);

    // Reset mid-transfer discards both entries
    rdy_dst2 = 1'b0;
    vld_src = 1'b1; pld_src = 4'h4; sel_src = 2'd2;
    repeat (2) tick();
    vld_src = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_vld", {28'd0, vld_all}, 32'h0);
    check_eq("midrst_rdy", {31'd0, rdy_src}, 32'h1);
    tick();
    rst_n = 1'b1;
    rdy_dst2 = 1'b1;
    repeat (2) tick();
    check_eq("midrst_after", {28'd0, vld_all}, 32'h0);

`ifdef DEMUX_1TO4_STALL_CNT_EN
    check_eq("stall_rst", {16'd0, stall_cnt}, 32'h0);
    rdy_dst0 = 1'b0;
    vld_src = 1'b1; pld_src = 4'h6; sel_src = 2'd0;
    tick();
    vld_src = 1'b0;
    repeat (3) tick();
    check_eq("stall_small", {16'd0, stall_cnt}, 32'h3);
    repeat (70000) tick();
    check_eq("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    tick();
    check_eq("stall_sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check_eq("stall_clr", {16'd0, stall_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    rdy_dst0 = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
